// File: rtl/lvds_timing_ctrl.sv
// Frame-timing generator (DE/HS/VS/X/Y) with frame-boundary port-mode and pattern sequencing.
// Optional build macro AUTO_CYCLE_EN adds automatic pattern advance every FRAMES_PER_PAT frames.
module lvds_timing_ctrl #(
   parameter int H_ACTIVE       = 1920,
   parameter int H_FP           = 88,
   parameter int H_SYNC         = 44,
   parameter int H_BP           = 148,
   parameter int V_ACTIVE       = 1080,
   parameter int V_FP           = 4,
   parameter int V_SYNC         = 5,
   parameter int V_BP           = 36,
   parameter int PAT_NUM        = 8,
   parameter int FRAMES_PER_PAT = 60
) (
   input  logic        iclk,
   input  logic        iRESET,
   input  logic        iEN,
   input  logic        iPORT_REQ,
   input  logic        iKEY_NEXT,
   input  logic        iAUTO,
   output logic        oDE,
   output logic        oHS,
   output logic        oVS,
   output logic [11:0] oX,
   output logic [11:0] oY,
   output logic        oFRAME_START,
   output logic        oTWO_PORT_SEL,
   output logic [3:0]  oPAT_ID
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_END  = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_END  = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
   localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [3:0]  PAT_LAST = 4'(PAT_NUM - 1);

   if ((H_ACTIVE % 2) != 0) begin : g_chk_h_even
      $error("lvds_timing_ctrl: H_ACTIVE must be even");
   end
   if (V_BP < 1) begin : g_chk_vbp
      $error("lvds_timing_ctrl: V_BP must be at least 1");
   end
   if ((PAT_NUM < 1) || (PAT_NUM > 16)) begin : g_chk_pat
      $error("lvds_timing_ctrl: PAT_NUM must be in 1..16");
   end
   if (FRAMES_PER_PAT < 1) begin : g_chk_fpp
      $error("lvds_timing_ctrl: FRAMES_PER_PAT must be at least 1");
   end
   if ((H_TOTAL > 4096) || (V_TOTAL > 4096)) begin : g_chk_cnt
      $error("lvds_timing_ctrl: totals must fit the 12-bit counters");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] hcnt_q, hcnt_d;
   logic [11:0] vcnt_q, vcnt_d;
   logic        key_q;
   logic        next_pend_q, next_pend_d;
   logic        two_port_q, two_port_d;
   logic [3:0]  pat_q, pat_d;
   logic        de_q, hs_q, vs_q, fs_q;
   logic [11:0] x_q, y_q;

   logic running_s;
   logic frame_end_s;
   logic key_rise_s;
   logic manual_s;
   logic advance_s;
   logic auto_fire_s;

   assign running_s   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign frame_end_s = running_s && (hcnt_q == H_END) && (vcnt_q == V_END);
   assign key_rise_s  = iKEY_NEXT && !key_q;
   assign manual_s    = key_rise_s || next_pend_q;

   // Run/drain sequencing and raster counters
   always_comb begin
      state_d = state_q;
      hcnt_d  = 12'd0;
      vcnt_d  = 12'd0;
      case (state_q)
         ST_IDLE: begin
            if (iEN) state_d = ST_RUN;
            else     state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (iEN)              state_d = ST_RUN;
            else if (frame_end_s) state_d = ST_IDLE;
            else                  state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (iEN)              state_d = ST_RUN;
            else if (frame_end_s) state_d = ST_IDLE;
            else                  state_d = ST_DRAIN;
         end
         default: state_d = ST_IDLE;
      endcase
      if (running_s) begin
         if (hcnt_q == H_END) begin
            hcnt_d = 12'd0;
            if (vcnt_q == V_END) vcnt_d = 12'd0;
            else                 vcnt_d = vcnt_q + 12'd1;
         end else begin
            hcnt_d = hcnt_q + 12'd1;
            vcnt_d = vcnt_q;
         end
      end else begin
         hcnt_d = 12'd0;
         vcnt_d = 12'd0;
      end
   end

   // Mode and pattern only move in IDLE or on the last count of a frame
   always_comb begin
      two_port_d  = two_port_q;
      next_pend_d = next_pend_q;
      advance_s   = 1'b0;
      if (state_q == ST_IDLE) begin
         two_port_d  = iPORT_REQ;
         advance_s   = manual_s;
         next_pend_d = 1'b0;
      end else if (frame_end_s) begin
         two_port_d  = iPORT_REQ;
         advance_s   = manual_s || auto_fire_s;
         next_pend_d = 1'b0;
      end else if (key_rise_s) begin
         next_pend_d = 1'b1;
      end else begin
         next_pend_d = next_pend_q;
      end
      if (!advance_s)              pat_d = pat_q;
      else if (pat_q >= PAT_LAST)  pat_d = 4'd0;
      else                         pat_d = pat_q + 4'd1;
   end

`ifdef AUTO_CYCLE_EN
   localparam int FCW = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
   localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_PAT - 1);

   logic [FCW-1:0] fc_q, fc_d;

   // Frame counter: restarts on iAUTO=0 or any manual advance
   always_comb begin
      fc_d        = fc_q;
      auto_fire_s = 1'b0;
      if (!iAUTO) begin
         fc_d = '0;
      end else if (frame_end_s) begin
         if (manual_s) begin
            fc_d = '0;
         end else if (fc_q == FC_LAST) begin
            fc_d        = '0;
            auto_fire_s = 1'b1;
         end else begin
            fc_d = fc_q + 1'b1;
         end
      end else if ((state_q == ST_IDLE) && manual_s) begin
         fc_d = '0;
      end else begin
         fc_d = fc_q;
      end
   end

   always_ff @(posedge iclk) begin
      if (!iRESET) fc_q <= '0;
      else         fc_q <= fc_d;
   end
`else
   logic unused_auto_s;
   assign unused_auto_s = iAUTO;
   assign auto_fire_s   = 1'b0;
`endif

   // All state and outputs; outputs decode the counters one cycle late
   always_ff @(posedge iclk) begin
      if (!iRESET) begin
         state_q     <= ST_IDLE;
         hcnt_q      <= 12'd0;
         vcnt_q      <= 12'd0;
         key_q       <= 1'b0;
         next_pend_q <= 1'b0;
         two_port_q  <= 1'b0;
         pat_q       <= 4'd0;
         de_q        <= 1'b0;
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         fs_q        <= 1'b0;
         x_q         <= 12'd0;
         y_q         <= 12'd0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         key_q       <= iKEY_NEXT;
         next_pend_q <= next_pend_d;
         two_port_q  <= two_port_d;
         pat_q       <= pat_d;
         de_q        <= running_s && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
         hs_q        <= running_s && (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
         vs_q        <= running_s && (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
         fs_q        <= running_s && (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
         x_q         <= running_s ? hcnt_q : 12'd0;
         y_q         <= running_s ? vcnt_q : 12'd0;
      end
   end

   assign oDE           = de_q;
   assign oHS           = hs_q;
   assign oVS           = vs_q;
   assign oX            = x_q;
   assign oY            = y_q;
   assign oFRAME_START  = fs_q;
   assign oTWO_PORT_SEL = two_port_q;
   assign oPAT_ID       = pat_q;
endmodule

// File: doc/lvds_timing_ctrl.md
# lvds_timing_ctrl

Frame-timing and mode sequencer for the LVDS pattern generator. Generates DE/HS/VS and pixel coordinates for the pattern engine, and owns the one-port/two-port select and the pattern index. Port-mode and pattern changes are deferred to a frame boundary so the two-port splitter never switches mid-frame. Sits between the key/switch front end and the pattern generator plus the two-port splitter.

## Interface
- H_ACTIVE, 1920, active pixels per line; must be even, and elaboration fails if it is odd.
- H_FP, 88, horizontal front porch in clocks.
- H_SYNC, 44, HS width in clocks.
- H_BP, 148, horizontal back porch in clocks.
- V_ACTIVE, 1080, active lines per frame.
- V_FP, 4, vertical front porch in lines.
- V_SYNC, 5, VS width in lines.
- V_BP, 36, vertical back porch in lines; must be ≥1.
- PAT_NUM, 8, number of patterns; range 1..16.
- FRAMES_PER_PAT, 60, frames per pattern in auto mode; must be ≥1.

Ports:
- iclk  in  1  pixel clock.
- iRESET  in  1  synchronous, active-low reset.
- iEN  in  1  run request (level).
- iPORT_REQ  in  1  requested mode; 1 = two-port.
- iKEY_NEXT  in  1  debounced key (level); a rising edge advances the pattern.
- iAUTO  in  1  auto-cycle enable (level).
- oDE  out  1  data enable.
- oHS  out  1  HS, active-high.
- oVS  out  1  VS, active-high.
- oX  out  12  pixel column, valid when oDE=1.
- oY  out  12  pixel row, valid when oDE=1.
- oFRAME_START  out  1  one-cycle pulse on pixel (0,0).
- oTWO_PORT_SEL  out  1  mode applied to the splitter.
- oPAT_ID  out  4  current pattern index.

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters:
  - hcnt runs 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments when hcnt wraps, runs 0..V_TOTAL-1, and wraps to 0.
- Region order per axis: active, front porch, sync, back porch.
  - DE = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - HS = H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC.
  - VS uses the same rule on vcnt, asserted for whole lines.
- FSM:
  - IDLE: counters held at 0; oDE/oHS/oVS/oFRAME_START = 0. iEN=1 → RUN.
  - RUN: counters free-run. iEN=0 → DRAIN.
  - DRAIN: the current frame completes. At the frame-end count (H_TOTAL-1, V_TOTAL-1) → IDLE. iEN=1 again → RUN, with no counter disturbance.
- Key edge detect: a rising edge of iKEY_NEXT sets the `next_pend` flag. Multiple edges within one frame collapse to one advance.
- Boundary update, at counter (H_TOTAL-1, V_TOTAL-1), i.e. the output cycle before oFRAME_START, which is always a DE=0 cycle:
  - oTWO_PORT_SEL ← iPORT_REQ.
  - If next_pend: oPAT_ID ← oPAT_ID+1, wrapping PAT_NUM-1 → 0, and next_pend is cleared.
- In IDLE both updates apply on the next cycle: oTWO_PORT_SEL tracks iPORT_REQ with 1 cycle of latency, and a key edge advances oPAT_ID directly.
- Any oTWO_PORT_SEL or oPAT_ID change at any other point is a defect.

## Timing
- All outputs are registered and lag the counters by 1 cycle.
- iEN sampled 1 in IDLE at edge N:
  - counters are (0,0) at N+1;
  - oFRAME_START, oDE, oX=0, oY=0 are asserted at N+2.
- Frame period is H_TOTAL×V_TOTAL clocks. oFRAME_START pulses exactly once per frame.
- Reset values, on the first edge with iRESET=0:
  - all outputs 0, including oPAT_ID=0 and oTWO_PORT_SEL=0;
  - FSM=IDLE, next_pend=0, frame counter=0.
- Reset mid-frame aborts immediately; there is no drain.
- Simultaneous key edge and boundary cycle: the edge is counted and applied at that same boundary.
- Frame with an equal pending advance and an auto advance: a single +1 is applied.

## Configuration
- AUTO_CYCLE_EN defined:
  - a frame counter increments at each boundary while iAUTO=1 in RUN/DRAIN;
  - on reaching FRAMES_PER_PAT it forces an advance at that boundary and clears to 0;
  - iAUTO=0 or a manual advance clears it.
- Not defined: iAUTO is ignored, no frame counter is built, and the pattern changes only on key edges.

## Test plan
All scenarios use H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (H_TOTAL=14, V_TOTAL=7, frame=98 clocks), unless a scenario overrides them.
- Start-up: reset, then iEN=1 at edge 0.
  - oFRAME_START at edge 2; oDE high for edges 2..9 with oX=0..7.
  - oHS high for 2 cycles starting 10 cycles after each line start.
  - Next oFRAME_START at edge 100.
- Mode defer: set iPORT_REQ=1 at pixel (3,1).
  - oTWO_PORT_SEL stays 0 until the cycle before the next oFRAME_START, then goes 1.
  - oDE=0 on the toggle cycle.
- Key collapse: three iKEY_NEXT edges in one frame with oPAT_ID=7 and PAT_NUM=8.
  - oPAT_ID becomes 0 once at the boundary, then holds.
- Drain: drop iEN mid-frame.
  - The frame completes; no further oFRAME_START occurs; FSM is IDLE with outputs 0.
  - Reasserting iEN during drain gives an uninterrupted next frame at the normal period.
- Reset mid-frame: iRESET=0 at pixel (5,2).
  - The next edge shows all outputs 0, oPAT_ID=0, oTWO_PORT_SEL=0.
- Auto, with AUTO_CYCLE_EN and FRAMES_PER_PAT=2, iAUTO=1:
  - oPAT_ID increments every 196 clocks.
  - A key edge restarts the 2-frame count.
